fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the async FIFO (wclk domain) between NUM_REQ

---
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin write-port arbiter with packet lock and burst cap
//
// Shares the single write port of the async FIFO (wclk domain) between
// NUM_REQ packet sources.
//
// The arbiter picks one owner in IDLE. It then holds that owner in BUSY
// until the owner ends its packet or reaches MAX_BURST words.
// Transfers are combinational from req_valid/wfull to winc.
// Grant, state, round-robin pointer and burst counter are registered.
//
// Ports:
//   wclk       write-domain clock
//   w_rst_n    async active-low reset, write domain
//   req_valid  per-requester word valid
//   req_data   packed requester words, word i at [i*data_width +: data_width]
//   req_last   per-requester end-of-packet marker
//   req_ready  per-requester accept (one-hot or zero)
//   grant      registered one-hot owner, zero when idle
//   wfull      FIFO full flag
//   winc       FIFO write enable
//   wdata      FIFO write data (owner's word while busy, zero when idle)
//   busy       arbiter holds a grant
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int data_width = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          wclk,
    input  logic                          w_rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*data_width-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          wfull,
    output logic                          winc,
    output logic [data_width-1:0]         wdata,
    output logic                          busy
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                  state, state_nxt;
    logic [NUM_REQ-1:0]      grant_nxt;
    logic [PTR_W-1:0]        rr_ptr, rr_ptr_nxt;
    logic [CNT_W-1:0]        burst_cnt, burst_cnt_nxt;

    logic                    pick_found;
    logic [PTR_W-1:0]        pick_idx;
    logic                    owner_valid;
    logic                    owner_last;
    logic [data_width-1:0]   owner_data;
    logic                    accept;

    // First valid requester, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_found && req_valid[PTR_W'((int'(rr_ptr) + k) % NUM_REQ)]) begin
                pick_found = 1'b1;
                pick_idx   = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Owner's signals, selected by the one-hot grant.
    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                owner_data = req_data[i*data_width +: data_width];
            end
        end
    end

    assign owner_valid = |(req_valid & grant);
    assign owner_last  = |(req_last & grant);

    assign accept    = (state == BUSY) && owner_valid && !wfull;
    assign winc      = accept;
    assign req_ready = accept ? grant : '0;
    assign wdata     = (state == BUSY) ? owner_data : '0;
    assign busy      = (state == BUSY);

    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        rr_ptr_nxt    = rr_ptr;
        burst_cnt_nxt = burst_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt     = BUSY;
                    grant_nxt     = NUM_REQ'(1) << pick_idx;
                    rr_ptr_nxt    = PTR_W'((int'(pick_idx) + 1) % NUM_REQ);
                    burst_cnt_nxt = '0;
                end
            end
            BUSY: begin
                if (accept) begin
                    burst_cnt_nxt = burst_cnt + CNT_W'(1);
                    // The word being accepted now is the last of the packet or of the burst.
                    if (owner_last || (burst_cnt == CNT_W'(MAX_BURST - 1))) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic            wclk = 1'b0;
    logic            w_rst_n;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    grant;
    logic            wfull;
    logic            winc;
    logic [DW-1:0]   wdata;
    logic            busy;

    always #5 wclk = ~wclk;

    fifo_wr_arbiter #(.NUM_REQ(N), .data_width(DW), .MAX_BURST(MB)) dut (
        .wclk(wclk), .w_rst_n(w_rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .grant(grant), .wfull(wfull),
        .winc(winc), .wdata(wdata), .busy(busy)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic       rstn;
        logic [3:0] v;
        logic [3:0] l;
        logic       f;
        logic [7:0] d0;
        logic [3:0] eg;
        logic       ew;
        logic [3:0] er;
        logic [7:0] ewd;
        logic       eb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rstn, input logic [3:0] v, input logic [3:0] l, input logic f,
                       input logic [7:0] d0, input logic [3:0] eg, input logic ew,
                       input logic [3:0] er, input logic [7:0] ewd, input logic eb);
        vec_t t;
        t.rstn = rstn; t.v = v; t.l = l; t.f = f; t.d0 = d0;
        t.eg = eg; t.ew = ew; t.er = er; t.ewd = ewd; t.eb = eb;
        tbl.push_back(t);
    endtask

    // Requester sources: word queues, valid held until ready.
    logic [7:0] src_d[N][$];
    bit         src_l[N][$];
    logic [7:0] exp_q[N][$];
    bit         hold[N];
    int         seq[N];
    logic [1:0] ord[$];
    int         wcnt;

    // Reference model: owner index (-1 = nobody), next search start, words in burst.
    int m_owner, m_ptr, m_cnt;
    int cyc = 0;

    task automatic add_pkt(input int id, input int len, input bit has_last);
        for (int k = 0; k < len; k++) begin
            logic [7:0] w;
            w = {2'(id), 6'(seq[id])};
            seq[id]++;
            src_d[id].push_back(w);
            src_l[id].push_back(has_last && (k == len - 1));
            exp_q[id].push_back(w);
        end
    endtask

    function automatic bit pending();
        bit p;
        p = 1'b0;
        for (int i = 0; i < N; i++) if (src_d[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic mcycle(input logic rstn, input int vprob, input int fprob);
        logic [3:0] eg, er;
        logic       ew, eb, acc;
        logic [7:0] ewd;
        @(negedge wclk);
        cyc++;
        w_rst_n = rstn;
        for (int i = 0; i < N; i++) begin
            if (!hold[i] && src_d[i].size() != 0 && int'($urandom_range(99)) < vprob) hold[i] = 1'b1;
            req_valid[i] = hold[i];
            req_data[i*DW +: DW] = hold[i] ? src_d[i][0] : 8'($urandom);
            req_last[i] = hold[i] ? src_l[i][0] : 1'($urandom);
        end
        wfull = (int'($urandom_range(99)) < fprob);
        #1;
        eg = '0; er = '0; ew = 1'b0; eb = 1'b0; ewd = '0; acc = 1'b0;
        if (rstn && m_owner >= 0) begin
            eg  = 4'b0001 << m_owner;
            eb  = 1'b1;
            ewd = req_data[m_owner*DW +: DW];
            acc = req_valid[m_owner] && !wfull;
            ew  = acc;
            er  = acc ? eg : 4'b0000;
        end
        check($sformatf("cyc%0d {grant,winc,ready,wdata,busy}", cyc),
              {grant, winc, req_ready, wdata, busy}, {eg, ew, er, ewd, eb});
        if (winc) begin
            logic [1:0] id;
            logic [7:0] e;
            id = wdata[7:6];
            wcnt++;
            ord.push_back(id);
            e = (exp_q[id].size() != 0) ? exp_q[id].pop_front() : ~wdata;
            check($sformatf("cyc%0d fifo word src%0d", cyc, id), wdata, e);
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && src_d[i].size() != 0) begin
                void'(src_d[i].pop_front());
                void'(src_l[i].pop_front());
                hold[i] = 1'b0;
            end
        end
        if (!rstn) begin
            m_owner = -1; m_ptr = 0; m_cnt = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (req_valid[c]) begin
                    m_owner = c; m_ptr = (c + 1) % N; m_cnt = 0;
                    break;
                end
            end
        end else if (acc) begin
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) m_owner = -1;
        end
    endtask

    initial begin
        int wbefore;
        w_rst_n = 1'b0; req_valid = '0; req_last = '0; req_data = '0; wfull = 1'b0;

        //  rstn v     l     f     d0     | grant  winc ready  wdata  busy
        add(0, 4'h0, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h0, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h0, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h1, 4'h0, 1'b0, 8'hAA, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h1, 4'h0, 1'b0, 8'hAA, 4'h1, 1, 4'h1, 8'hAA, 1);
        add(1, 4'h1, 4'h0, 1'b0, 8'hBB, 4'h1, 1, 4'h1, 8'hBB, 1);
        add(1, 4'h1, 4'h1, 1'b0, 8'hCC, 4'h1, 1, 4'h1, 8'hCC, 1);
        add(1, 4'h0, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(0, 4'h0, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h1, 1, 4'h1, 8'h11, 1);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h2, 1, 4'h2, 8'h22, 1);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h4, 1, 4'h4, 8'h33, 1);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h8, 1, 4'h8, 8'h44, 1);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'hF, 4'hF, 1'b0, 8'h11, 4'h1, 1, 4'h1, 8'h11, 1);
        add(1, 4'h0, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h4, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h4, 4'h0, 1'b1, 8'h11, 4'h4, 0, 4'h0, 8'h33, 1);
        add(1, 4'h4, 4'h4, 1'b0, 8'h11, 4'h4, 1, 4'h4, 8'h33, 1);
        add(1, 4'h0, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h2, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h0, 4'h0, 1'b0, 8'h11, 4'h2, 0, 4'h0, 8'h22, 1);
        add(1, 4'hA, 4'h2, 1'b0, 8'h11, 4'h2, 1, 4'h2, 8'h22, 1);
        add(1, 4'h8, 4'h8, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h8, 4'h8, 1'b0, 8'h11, 4'h8, 1, 4'h8, 8'h44, 1);
        add(1, 4'h0, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h1, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h1, 4'h0, 1'b1, 8'h11, 4'h1, 0, 4'h0, 8'h11, 1);
        add(0, 4'h1, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h9, 4'h9, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);
        add(1, 4'h9, 4'h9, 1'b0, 8'h11, 4'h1, 1, 4'h1, 8'h11, 1);
        add(1, 4'h0, 4'h0, 1'b0, 8'h11, 4'h0, 0, 4'h0, 8'h00, 0);

        foreach (tbl[i]) begin
            @(negedge wclk);
            w_rst_n   = tbl[i].rstn;
            req_valid = tbl[i].v;
            req_last  = tbl[i].l;
            wfull     = tbl[i].f;
            req_data  = {24'h443322, tbl[i].d0};
            #1;
            check($sformatf("row%0d grant", i), grant, tbl[i].eg);
            check($sformatf("row%0d winc", i), winc, tbl[i].ew);
            check($sformatf("row%0d req_ready", i), req_ready, tbl[i].er);
            check($sformatf("row%0d wdata", i), wdata, tbl[i].ewd);
            check($sformatf("row%0d busy", i), busy, tbl[i].eb);
        end

        m_owner = -1; m_ptr = 0; m_cnt = 0;
        for (int i = 0; i < N; i++) begin hold[i] = 1'b0; seq[i] = 0; end

        // Burst cap: req1 streams 40 words without last, req2 sends a 3-word packet.
        mcycle(0, 100, 0);
        add_pkt(1, 40, 1'b0);
        add_pkt(2, 3, 1'b1);
        ord.delete();
        wcnt = 0;
        for (int c = 0; c < 200 && pending(); c++) mcycle(1, 100, 0);
        repeat (2) mcycle(1, 100, 0);
        check("burst drained", pending(), 0);
        check("burst winc count", wcnt, 43);
        for (int k = 0; k < 43 && k < ord.size(); k++)
            check($sformatf("burst order word%0d", k), ord[k], (k >= 16 && k < 19) ? 2'd2 : 2'd1);

        // Backpressure: wfull for 5 cycles after two words of a 6-word packet.
        mcycle(0, 100, 0);
        wcnt = 0;
        add_pkt(0, 6, 1'b1);
        repeat (3) mcycle(1, 100, 0);
        check("bp words before full", wcnt, 2);
        wbefore = wcnt;
        repeat (5) mcycle(1, 100, 100);
        check("bp no write while full", wcnt, wbefore);
        for (int c = 0; c < 50 && pending(); c++) mcycle(1, 100, 0);
        check("bp winc count", wcnt, 6);
        check("bp words left", exp_q[0].size(), 0);

        // Randomized traffic: all packets end with last, lengths cross the burst cap.
        mcycle(0, 100, 0);
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++)
                if (src_d[i].size() == 0 && $urandom_range(9) == 0)
                    add_pkt(i, int'($urandom_range(1, 20)), 1'b1);
            mcycle(1, 70, 20);
        end
        for (int c = 0; c < 1000 && pending(); c++) mcycle(1, 100, 0);
        for (int i = 0; i < N; i++)
            check($sformatf("rand src%0d words left", i), exp_q[i].size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
